// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture: recovers per-digit hex value and dot from a multiplexed seven-segment bus
module seg7_scan_capture #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a,
    input  logic                    b,
    input  logic                    c,
    input  logic                    d,
    input  logic                    e,
    input  logic                    f,
    input  logic                    g,
    input  logic                    dot,
    input  logic [NUM_DIGITS-1:0]   dig_sel,
    output logic [4*NUM_DIGITS-1:0] hex,
    output logic [NUM_DIGITS-1:0]   dots,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    frame_valid
);
    localparam int SW = NUM_DIGITS + 8;
    localparam int CW = STABLE_CYCLES > 1 ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CW-1:0] CMAX = CW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    state_t                state;
    logic [SW-1:0]         s_reg;
    logic [SW-1:0]         sample;
    logic [CW-1:0]         cnt;
    logic [NUM_DIGITS-1:0] seen;
    logic [NUM_DIGITS-1:0] seen_next;
    logic                  one_hot;
    logic                  same;
    logic                  capture;
    logic [4:0]            dec;

    // {valid, value}; anything outside the 16 glyphs is flagged invalid
    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = 5'h00;
        case (p)
            7'h7E: r = 5'h10;
            7'h30: r = 5'h11;
            7'h6D: r = 5'h12;
            7'h79: r = 5'h13;
            7'h33: r = 5'h14;
            7'h5B: r = 5'h15;
            7'h5F: r = 5'h16;
            7'h70: r = 5'h17;
            7'h7F: r = 5'h18;
            7'h7B: r = 5'h19;
            7'h77: r = 5'h1A;
            7'h1F: r = 5'h1B;
            7'h4E: r = 5'h1C;
            7'h3D: r = 5'h1D;
            7'h4F: r = 5'h1E;
            7'h47: r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    // s_reg layout: {dig_sel, a..g, dot}
    assign sample    = {dig_sel, a, b, c, d, e, f, g, dot};
    assign one_hot   = $onehot(dig_sel);
    assign same      = sample == s_reg;
    assign capture   = state == SETTLE && same && one_hot && cnt == CMAX;
    assign seen_next = seen | dig_sel;
    assign dec       = decode(s_reg[7:1]);

    // sampler, stability counter, scan FSM and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            s_reg       <= '0;
            cnt         <= '0;
            seen        <= '0;
            hex         <= '0;
            dots        <= '0;
            err         <= '0;
            frame_valid <= 1'b0;
        end else begin
            s_reg       <= sample;
            cnt         <= (same && one_hot) ? (cnt == CMAX ? cnt : cnt + 1'b1) : '0;
            frame_valid <= 1'b0;
            state       <= !one_hot ? IDLE : capture ? HELD : (same && state == HELD) ? HELD : SETTLE;
            if (capture) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (s_reg[8+i]) begin
                        dots[i] <= s_reg[0];
                        err[i]  <= ~dec[4];
                        if (dec[4]) hex[4*i +: 4] <= dec[3:0];
                    end
                end
                if (&seen_next) begin
                    seen        <= '0;
                    frame_valid <= 1'b1;
                end else begin
                    seen <= seen_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_seg7_scan_capture.sv
// tb_seg7_scan_capture: scoreboard bench for the seven-segment scan capture block
module tb_seg7_scan_capture;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = '0;
    logic        dot = 1'b0;
    logic [3:0]  dig_sel = '0;
    logic [15:0] hex;
    logic [3:0]  dots;
    logic [3:0]  err;
    logic        frame_valid;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;

    typedef struct {
        int          cyc;
        logic [15:0] hex;
        logic [3:0]  dots;
        logic [3:0]  err;
        logic        fv;
    } exp_t;

    exp_t q[$];

    seg7_scan_capture dut (
        .clk(clk), .rst(rst),
        .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
        .dot(dot), .dig_sel(dig_sel),
        .hex(hex), .dots(dots), .err(err), .frame_valid(frame_valid)
    );

    always #5 clk = ~clk;

    // cycle stamp: value equals the number of rising edges seen so far
    always @(posedge clk) cyc <= cyc + 1;

    // monitor: expected outputs change only on scheduled edges; frame_valid only on them
    logic [15:0] cur_hex = '0;
    logic [3:0]  cur_dots = '0;
    logic [3:0]  cur_err = '0;
    always @(negedge clk) begin
        logic exp_fv;
        exp_t e;
        if (cyc > 0) begin
            exp_fv = 1'b0;
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                mismatched++;
                $display("FAIL stale_entry: expected update at cycle %0d never consumed (now %0d)", e.cyc, cyc);
            end
            if (q.size() > 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                cur_hex  = e.hex;
                cur_dots = e.dots;
                cur_err  = e.err;
                exp_fv   = e.fv;
            end
            compared++;
            if ({hex, dots, err, frame_valid} !== {cur_hex, cur_dots, cur_err, exp_fv}) begin
                mismatched++;
                $display("FAIL cycle_%0d: got hex=%h dots=%b err=%b fv=%b, want hex=%h dots=%b err=%b fv=%b",
                         cyc, hex, dots, err, frame_valid, cur_hex, cur_dots, cur_err, exp_fv);
            end
        end
    end

    task automatic drive(input logic [3:0] sel, input logic [6:0] pat, input logic dt);
        dig_sel = sel;
        seg     = pat;
        dot     = dt;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // capture lands on the fifth edge after the inputs settle
    task automatic expect_at(input int k, input logic [15:0] h, input logic [3:0] dt,
                             input logic [3:0] er, input logic fv);
        q.push_back('{cyc + k, h, dt, er, fv});
    endtask

    task automatic chk(input string name, input logic [24:0] got, input logic [24:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        wait_edges(3);
        chk("reset_values", {hex, dots, err, frame_valid}, 25'h0);
        rst = 1'b0;
        wait_edges(20);
        chk("blank_bus", {hex, dots, err, frame_valid}, 25'h0);

        drive(4'b0001, 7'h7E, 1'b0); expect_at(5, 16'h0000, 4'b0000, 4'b0000, 1'b0); wait_edges(8);
        drive(4'b0010, 7'h30, 1'b0); expect_at(5, 16'h0010, 4'b0000, 4'b0000, 1'b0); wait_edges(8);
        drive(4'b0100, 7'h6D, 1'b1); expect_at(5, 16'h0210, 4'b0100, 4'b0000, 1'b0); wait_edges(8);
        drive(4'b1000, 7'h79, 1'b0); expect_at(5, 16'h3210, 4'b0100, 4'b0000, 1'b1); wait_edges(8);
        chk("scan_frame", {hex, dots, err, frame_valid}, {16'h3210, 4'b0100, 4'b0000, 1'b0});

        drive(4'b0010, 7'h4F, 1'b0); wait_edges(4);
        drive(4'b0000, 7'h00, 1'b0); wait_edges(6);
        chk("short_dwell", {hex, dots, err, frame_valid}, {16'h3210, 4'b0100, 4'b0000, 1'b0});

        drive(4'b0001, 7'h77, 1'b0); expect_at(5, 16'h321A, 4'b0100, 4'b0000, 1'b0); wait_edges(8);
        drive(4'b0001, 7'h01, 1'b0); expect_at(5, 16'h321A, 4'b0100, 4'b0001, 1'b0); wait_edges(8);
        chk("invalid_keeps_hex", {hex, dots, err, frame_valid}, {16'h321A, 4'b0100, 4'b0001, 1'b0});
        drive(4'b0001, 7'h47, 1'b0); expect_at(5, 16'h321F, 4'b0100, 4'b0000, 1'b0); wait_edges(8);

        drive(4'b0011, 7'h5B, 1'b0); wait_edges(10);
        chk("two_hot_blank", {hex, dots, err, frame_valid}, {16'h321F, 4'b0100, 4'b0000, 1'b0});

        drive(4'b0010, 7'h5B, 1'b0); wait_edges(2);
        drive(4'b0010, 7'h5F, 1'b0); wait_edges(1);
        drive(4'b0010, 7'h5B, 1'b0); expect_at(5, 16'h325F, 4'b0100, 4'b0000, 1'b0); wait_edges(4);
        chk("glitch_restart", {hex, dots, err, frame_valid}, {16'h321F, 4'b0100, 4'b0000, 1'b0});
        wait_edges(4);

        drive(4'b0100, 7'h6D, 1'b1); wait_edges(8);
        drive(4'b1000, 7'h4E, 1'b0); expect_at(5, 16'hC25F, 4'b0100, 4'b0000, 1'b1); wait_edges(8);

        drive(4'b0100, 7'h5F, 1'b0); wait_edges(2);
        rst = 1'b1;
        expect_at(0, 16'h0000, 4'b0000, 4'b0000, 1'b0);
        #1;
        chk("async_reset", {hex, dots, err, frame_valid}, 25'h0);
        wait_edges(1);
        rst = 1'b0;
        expect_at(5, 16'h0600, 4'b0000, 4'b0000, 1'b0);
        wait_edges(4);
        chk("post_reset_wait", {hex, dots, err, frame_valid}, 25'h0);
        wait_edges(4);
        chk("post_reset_capture", {hex, dots, err, frame_valid}, {16'h0600, 4'b0000, 4'b0000, 1'b0});

        drive(4'b0000, 7'h00, 1'b0); wait_edges(3);
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL queue_drained: got %0d pending want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
